// File: rtl/mux_ser_pkg.sv
// Shared definitions for the mux bit serializer: word/select widths, the
// FSM state encoding and the start/end select positions for either order.
package mux_ser_pkg;

  localparam int WORD_W = 16;
  localparam int SEL_W  = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  // First select position of a word.
  function automatic logic [SEL_W-1:0] start_idx(input bit msb_first);
    return msb_first ? 4'd15 : 4'd0;
  endfunction

  // Final select position of a word; reaching it terminates the data beats.
  function automatic logic [SEL_W-1:0] end_idx(input bit msb_first);
    return msb_first ? 4'd0 : 4'd15;
  endfunction

endpackage

// File: rtl/mux16_to_1.sv
// 16:1 bit-select mux: out = in[sel].
module mux16_to_1
  import mux_ser_pkg::*;
(
  input  logic [WORD_W-1:0] in,
  input  logic [SEL_W-1:0]  sel,
  output logic              out
);

  assign out = in[sel];

endmodule

// File: rtl/mux_bit_serializer.sv
// Parallel-to-serial stage driving the 16:1 bit-select mux.
// Accepts a 16-bit word over valid/ready, then walks the mux select through
// all 16 positions, one position per accepted output beat.
// Optional feature: define MUX_SER_PARITY_EN to append an even-parity beat.
module mux_bit_serializer
  import mux_ser_pkg::*;
#(
  parameter bit MSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_bit,
  output logic [SEL_W-1:0]  out_idx,
  output logic              out_last,
  output logic              busy
);

  localparam logic [SEL_W-1:0] START_IDX = start_idx(MSB_FIRST);
  localparam logic [SEL_W-1:0] END_IDX   = end_idx(MSB_FIRST);
  localparam logic [3:0]       GAP_LOAD  = 4'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t            state_q, state_nxt;
  logic [WORD_W-1:0] word_q;
  logic [SEL_W-1:0]  idx_q;
  logic [SEL_W-1:0]  idx_step;
  logic [3:0]        gap_q;
  logic              last_data;
  logic              is_last;
  logic              beat;
  logic              accept;
  logic              mux_bit;
  logic              beat_bit;

  assign last_data = (idx_q == END_IDX);
  assign idx_step  = MSB_FIRST ? idx_q - 4'd1 : idx_q + 4'd1;

`ifdef MUX_SER_PARITY_EN
  logic par_q;
  // The word ends on the parity beat, not on the final data position.
  assign is_last  = par_q;
  assign beat_bit = par_q ? ^word_q : mux_bit;
`else
  assign is_last  = last_data;
  assign beat_bit = mux_bit;
`endif

  assign out_valid = (state_q == SHIFT);
  assign out_last  = out_valid & is_last;
  assign out_bit   = out_valid & beat_bit;
  assign out_idx   = idx_q;
  assign busy      = (state_q != IDLE);
  assign beat      = out_valid & out_ready;
  // A new word may enter while idle, or on the edge that retires the last beat.
  assign in_ready  = (state_q == IDLE) | (out_valid & is_last & out_ready);
  assign accept    = in_valid & in_ready;

  mux16_to_1 u_mux (
    .in  (word_q),
    .sel (idx_q),
    .out (mux_bit)
  );

  // Next-state decode.
  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state_q;
    unique case (state_q)
      IDLE:  if (in_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (beat) begin
          if (is_last)             state_nxt = in_valid ? SHIFT : IDLE;
          else if (GAP_CYCLES > 0) state_nxt = GAP;
        end
      end
      GAP:     if (gap_q == 4'd0) state_nxt = SHIFT;
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_nxt;
  end

  // Word, select index, gap counter (and parity-beat flag) updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      idx_q  <= START_IDX;
      gap_q  <= 4'd0;
`ifdef MUX_SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (accept) begin
      word_q <= in_data;
      idx_q  <= START_IDX;
`ifdef MUX_SER_PARITY_EN
      par_q  <= 1'b0;
`endif
    end else if (beat && !is_last) begin
`ifdef MUX_SER_PARITY_EN
      // After the final data position the index holds for the parity beat.
      if (last_data) par_q <= 1'b1;
      else           idx_q <= idx_step;
`else
      idx_q <= idx_step;
`endif
      gap_q <= GAP_LOAD;
    end else if (state_q == GAP && gap_q != 4'd0) begin
      gap_q <= gap_q - 4'd1;
    end
  end

endmodule

// File: tb/tb_mux_bit_serializer.sv
// Self-checking bench for mux_bit_serializer: expected beats are pushed to a
// queue when a word is driven and popped as the DUT emits beats.
module tb_mux_bit_serializer;

  typedef struct packed {
    logic       b;
    logic [3:0] idx;
    logic       last;
  } beat_t;

`ifdef MUX_SER_PARITY_EN
  localparam int NB = 17;
`else
  localparam int NB = 16;
`endif

  logic        clk, rst_n;
  logic        in_valid, in_ready, out_valid, out_ready, out_bit, out_last, busy;
  logic [15:0] in_data;
  logic [3:0]  out_idx;
  logic        in_valid2, in_ready2, out_valid2, out_ready2, out_bit2, out_last2, busy2;
  logic [15:0] in_data2;
  logic [3:0]  out_idx2;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];

  mux_bit_serializer dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_bit(out_bit), .out_idx(out_idx), .out_last(out_last), .busy(busy)
  );

  mux_bit_serializer #(.MSB_FIRST(1'b0), .GAP_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
    .in_data(in_data2), .out_valid(out_valid2), .out_ready(out_ready2),
    .out_bit(out_bit2), .out_idx(out_idx2), .out_last(out_last2), .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Expected beat sequence of one word.
  task automatic push_word(input logic [15:0] w, input bit msb);
    for (int k = 0; k < 16; k++) begin
      beat_t e;
      e.idx  = msb ? 4'(15 - k) : 4'(k);
      e.b    = w[e.idx];
`ifdef MUX_SER_PARITY_EN
      e.last = 1'b0;
`else
      e.last = (k == 15);
`endif
      exp_q.push_back(e);
    end
`ifdef MUX_SER_PARITY_EN
    exp_q.push_back('{b: ^w, idx: (msb ? 4'd0 : 4'd15), last: 1'b1});
`endif
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    in_valid2 = 1'b0; in_data2 = '0; out_ready2 = 1'b0;
    #12;
    checks++;
    if ({out_valid, out_bit, out_last, busy, in_ready, out_idx} !== {5'b00001, 4'd15}) begin
      errors++;
      $display("FAIL reset msb: got v=%b b=%b l=%b busy=%b rdy=%b idx=%0d, expected 0 0 0 0 1 15",
               out_valid, out_bit, out_last, busy, in_ready, out_idx);
    end
    checks++;
    if ({out_valid2, busy2, in_ready2, out_idx2} !== {3'b001, 4'd0}) begin
      errors++;
      $display("FAIL reset lsb: got v=%b busy=%b rdy=%b idx=%0d, expected 0 0 1 0",
               out_valid2, busy2, in_ready2, out_idx2);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic();
    beat_t b;
    exp_q.delete(); push_word(16'hA5C3, 1'b1);
    @(negedge clk); in_valid = 1'b1; in_data = 16'hA5C3; out_ready = 1'b1;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk); in_valid = 1'b0;
      b = exp_q.pop_front();
      checks++;
      if ({out_valid, out_bit, out_idx, out_last} !== {1'b1, b.b, b.idx, b.last}) begin
        errors++;
        $display("FAIL basic beat %0d: got v=%b bit=%b idx=%0d last=%b, expected v=1 bit=%b idx=%0d last=%b",
                 k, out_valid, out_bit, out_idx, out_last, b.b, b.idx, b.last);
      end
      if (k == NB - 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL basic last in_ready: got %b, expected 1", in_ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL basic idle: got v=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    beat_t       b;
    logic [3:0]  pat = 4'b1001;
    logic        hold = 1'b0, hb;
    logic [3:0]  hi;
    int          beats = 0, cyc = 0;
    exp_q.delete(); push_word(16'h8001, 1'b1);
    @(negedge clk); in_valid = 1'b1; in_data = 16'h8001; out_ready = 1'b1;
    while (beats < NB && cyc < 200) begin
      @(negedge clk); in_valid = 1'b0;
      if (hold) begin
        hold = 1'b0;
        checks++;
        if ({out_valid, out_bit, out_idx} !== {1'b1, hb, hi}) begin
          errors++;
          $display("FAIL bp stable: got v=%b bit=%b idx=%0d, expected v=1 bit=%b idx=%0d",
                   out_valid, out_bit, out_idx, hb, hi);
        end
      end
      out_ready = pat[cyc % 4];
      if (out_valid) begin
        if (out_ready) begin
          beats++;
          if (exp_q.size() == 0) begin
            checks++; errors++; $display("FAIL bp extra beat: got idx=%0d, expected none", out_idx);
          end else begin
            b = exp_q.pop_front();
            checks++;
            if ({out_bit, out_idx, out_last} !== {b.b, b.idx, b.last}) begin
              errors++;
              $display("FAIL bp beat: got bit=%b idx=%0d last=%b, expected bit=%b idx=%0d last=%b",
                       out_bit, out_idx, out_last, b.b, b.idx, b.last);
            end
          end
        end else begin
          hold = 1'b1; hb = out_bit; hi = out_idx;
        end
      end
      cyc++;
    end
    @(negedge clk); out_ready = 1'b1;
    checks++;
    if (beats != NB || exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL bp count: got beats=%0d left=%0d busy=%b, expected beats=%0d left=0 busy=0",
               beats, exp_q.size(), busy, NB);
    end
  endtask

  task automatic test_back_to_back();
    beat_t b;
    exp_q.delete(); push_word(16'hFFFF, 1'b1); push_word(16'h0000, 1'b1);
    @(negedge clk); in_valid = 1'b1; in_data = 16'hFFFF; out_ready = 1'b1;
    for (int k = 0; k < 2 * NB; k++) begin
      @(negedge clk);
      if (k == 0)  in_data  = 16'h0000;
      if (k == NB) in_valid = 1'b0;
      b = exp_q.pop_front();
      checks++;
      if ({out_valid, out_bit, out_idx, out_last} !== {1'b1, b.b, b.idx, b.last}) begin
        errors++;
        $display("FAIL b2b beat %0d: got v=%b bit=%b idx=%0d last=%b, expected v=1 bit=%b idx=%0d last=%b",
                 k, out_valid, out_bit, out_idx, out_last, b.b, b.idx, b.last);
      end
      if (k == NB - 1) begin
        checks++;
        if (in_ready !== 1'b1) begin
          errors++; $display("FAIL b2b reload in_ready: got %b, expected 1", in_ready);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, busy} !== 2'b00) begin
      errors++; $display("FAIL b2b idle: got v=%b busy=%b, expected 0 0", out_valid, busy);
    end
  endtask

  task automatic test_gap_lsb();
    beat_t b;
    exp_q.delete(); push_word(16'h0001, 1'b0);
    @(negedge clk); in_valid2 = 1'b1; in_data2 = 16'h0001; out_ready2 = 1'b1;
    for (int k = 0; k <= (NB - 1) * 3; k++) begin
      @(negedge clk); in_valid2 = 1'b0;
      if (k % 3 == 0) begin
        b = exp_q.pop_front();
        checks++;
        if ({out_valid2, out_bit2, out_idx2, out_last2} !== {1'b1, b.b, b.idx, b.last}) begin
          errors++;
          $display("FAIL gap beat cyc %0d: got v=%b bit=%b idx=%0d last=%b, expected v=1 bit=%b idx=%0d last=%b",
                   k, out_valid2, out_bit2, out_idx2, out_last2, b.b, b.idx, b.last);
        end
      end else begin
        checks++;
        if ({out_valid2, out_bit2, in_ready2} !== 3'b000) begin
          errors++;
          $display("FAIL gap idle cyc %0d: got v=%b bit=%b rdy=%b, expected 0 0 0",
                   k, out_valid2, out_bit2, in_ready2);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid2, busy2} !== 2'b00) begin
      errors++; $display("FAIL gap idle end: got v=%b busy=%b, expected 0 0", out_valid2, busy2);
    end
  endtask

  task automatic test_reset_mid_word();
    beat_t b;
    exp_q.delete(); push_word(16'h1234, 1'b1);
    @(negedge clk); in_valid = 1'b1; in_data = 16'h1234; out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); in_valid = 1'b0;
      b = exp_q.pop_front();
      checks++;
      if ({out_valid, out_bit, out_idx} !== {1'b1, b.b, b.idx}) begin
        errors++;
        $display("FAIL rst pre beat %0d: got v=%b bit=%b idx=%0d, expected v=1 bit=%b idx=%0d",
                 k, out_valid, out_bit, out_idx, b.b, b.idx);
      end
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, busy, in_ready, out_idx} !== {3'b001, 4'd15}) begin
      errors++;
      $display("FAIL rst async: got v=%b busy=%b rdy=%b idx=%0d, expected 0 0 1 15",
               out_valid, busy, in_ready, out_idx);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({out_valid, busy, in_ready} !== 3'b001) begin
      errors++;
      $display("FAIL rst release: got v=%b busy=%b rdy=%b, expected 0 0 1", out_valid, busy, in_ready);
    end
    exp_q.delete(); push_word(16'h0003, 1'b1);
    in_valid = 1'b1; in_data = 16'h0003;
    for (int k = 0; k < NB; k++) begin
      @(negedge clk); in_valid = 1'b0;
      b = exp_q.pop_front();
      checks++;
      if ({out_valid, out_bit, out_idx, out_last} !== {1'b1, b.b, b.idx, b.last}) begin
        errors++;
        $display("FAIL rst post beat %0d: got v=%b bit=%b idx=%0d last=%b, expected v=1 bit=%b idx=%0d last=%b",
                 k, out_valid, out_bit, out_idx, out_last, b.b, b.idx, b.last);
      end
    end
    @(negedge clk);
  endtask

`ifdef MUX_SER_PARITY_EN
  task automatic test_parity();
    @(negedge clk); in_valid = 1'b1; in_data = 16'h0007; out_ready = 1'b1;
    for (int k = 0; k < 17; k++) begin
      @(negedge clk); in_valid = 1'b0;
      if (k == 15) begin
        checks++;
        if ({out_valid, out_last, out_idx} !== {2'b10, 4'd0}) begin
          errors++;
          $display("FAIL parity 16th: got v=%b last=%b idx=%0d, expected 1 0 0", out_valid, out_last, out_idx);
        end
      end
      if (k == 16) begin
        checks++;
        if ({out_valid, out_bit, out_last, out_idx} !== {3'b111, 4'd0}) begin
          errors++;
          $display("FAIL parity beat: got v=%b bit=%b last=%b idx=%0d, expected 1 1 1 0",
                   out_valid, out_bit, out_last, out_idx);
        end
      end
    end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_gap_lsb();
    test_reset_mid_word();
`ifdef MUX_SER_PARITY_EN
    test_parity();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
